// File: rtl/dmem_access_unit_pkg.sv
// Shared data-memory access encodings (dm_ctrl) and the access legality rule.
// Pure declarations: no latency, no flow control.
package dmem_access_unit_pkg;

  localparam logic [2:0] DM_WORD     = 3'b000;
  localparam logic [2:0] DM_HALF     = 3'b001;
  localparam logic [2:0] DM_HALF_U   = 3'b010;
  localparam logic [2:0] DM_BYTE     = 3'b011;
  localparam logic [2:0] DM_BYTE_U   = 3'b100;

  // Natural alignment only; encodings above DM_BYTE_U are illegal.
  function automatic logic dm_legal(input logic [2:0] ctrl, input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (ctrl)
      DM_WORD:              ok = (addr_lo == 2'b00);
      DM_HALF, DM_HALF_U:   ok = ~addr_lo[0];
      DM_BYTE, DM_BYTE_U:   ok = 1'b1;
      default:              ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_access_unit_lane.sv
// dmem_lane_align: store byte-enable/lane replication, load lane select and extension, legality.
// Purely combinational, zero latency, no flow control.
module dmem_lane_align
  import dmem_access_unit_pkg::*;
(
  input  logic [2:0]  i_st_ctrl,
  input  logic [1:0]  i_st_addr_lo,
  input  logic [31:0] i_st_wdata,
  input  logic [2:0]  i_ld_ctrl,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [31:0] i_ld_rdata,
  output logic [3:0]  o_st_be,
  output logic [31:0] o_st_wdata,
  output logic [31:0] o_ld_data,
  output logic        o_legal
);

  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;

  assign o_legal = dm_legal(i_st_ctrl, i_st_addr_lo);

  always_comb begin
    o_st_be    = 4'b1111;
    o_st_wdata = i_st_wdata;
    case (i_st_ctrl)
      DM_BYTE, DM_BYTE_U: begin
        o_st_be    = 4'b0001 << i_st_addr_lo;
        o_st_wdata = {4{i_st_wdata[7:0]}};
      end
      DM_HALF, DM_HALF_U: begin
        o_st_be    = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_st_wdata = {2{i_st_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_ld_byte = i_ld_rdata[7:0];
    case (i_ld_addr_lo)
      2'd1:    w_ld_byte = i_ld_rdata[15:8];
      2'd2:    w_ld_byte = i_ld_rdata[23:16];
      2'd3:    w_ld_byte = i_ld_rdata[31:24];
      default: w_ld_byte = i_ld_rdata[7:0];
    endcase
    w_ld_half = i_ld_addr_lo[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];

    o_ld_data = i_ld_rdata;
    case (i_ld_ctrl)
      DM_BYTE:   o_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
      DM_BYTE_U: o_ld_data = {24'd0, w_ld_byte};
      DM_HALF:   o_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
      DM_HALF_U: o_ld_data = {16'd0, w_ld_half};
      default:   o_ld_data = i_ld_rdata;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// CPU MEM-stage to word-memory bridge: IDLE->ACCESS->DONE per access, min 3 cycles, stalls CPU while busy.
// Holds mem_req until mem_ack or TIMEOUT_CYCLES ACCESS cycles; illegal accesses pulse misalign without a request.
module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wdata,
  input  logic [2:0]  i_cpu_dm_ctrl,
  output logic [31:0] o_cpu_rdata,
  output logic        o_cpu_stall,
  output logic        o_cpu_misalign,
  output logic        o_cpu_bus_err,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cnt;
  logic [2:0]  r_ld_ctrl;
  logic [1:0]  r_ld_addr_lo;
  logic [31:0] r_cpu_rdata, r_mem_addr, r_mem_wdata;
  logic [3:0]  r_mem_be;
  logic        r_mem_req, r_mem_we, r_misalign, r_bus_err;

  logic [3:0]  w_st_be;
  logic [31:0] w_st_wdata, w_ld_data;
  logic        w_legal, w_start, w_reject, w_timeout;

  dmem_lane_align u_lane (
    .i_st_ctrl    (i_cpu_dm_ctrl),
    .i_st_addr_lo (i_cpu_addr[1:0]),
    .i_st_wdata   (i_cpu_wdata),
    .i_ld_ctrl    (r_ld_ctrl),
    .i_ld_addr_lo (r_ld_addr_lo),
    .i_ld_rdata   (i_mem_rdata),
    .o_st_be      (w_st_be),
    .o_st_wdata   (w_st_wdata),
    .o_ld_data    (w_ld_data),
    .o_legal      (w_legal)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_reject    = 1'b0;
    w_timeout   = 1'b0;
    o_cpu_stall = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_start     = i_cpu_req & w_legal;
        w_reject    = i_cpu_req & ~w_legal;
        o_cpu_stall = w_start;
        if (w_start) w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        o_cpu_stall = 1'b1;
        // Ack has priority over a coincident timeout.
        w_timeout   = ~i_mem_ack & (r_cnt == TO_LAST);
        if (i_mem_ack || w_timeout) w_state_nxt = ST_DONE;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt        <= 8'd0;
      r_ld_ctrl    <= DM_WORD;
      r_ld_addr_lo <= 2'b00;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_wdata  <= 32'd0;
      r_mem_be     <= 4'd0;
      r_cpu_rdata  <= 32'd0;
      r_misalign   <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      r_misalign <= w_reject;
      r_bus_err  <= 1'b0;
      r_cnt      <= (r_state == ST_ACCESS) ? r_cnt + 8'd1 : 8'd0;
      if (w_start) begin
        r_mem_req    <= 1'b1;
        r_mem_we     <= i_cpu_we;
        r_mem_addr   <= {i_cpu_addr[31:2], 2'b00};
        r_mem_wdata  <= w_st_wdata;
        r_mem_be     <= i_cpu_we ? w_st_be : 4'b1111;
        r_ld_ctrl    <= i_cpu_dm_ctrl;
        r_ld_addr_lo <= i_cpu_addr[1:0];
      end
      if (r_state == ST_ACCESS) begin
        if (i_mem_ack) begin
          r_mem_req <= 1'b0;
          if (!r_mem_we) r_cpu_rdata <= w_ld_data;
        end else if (w_timeout) begin
          r_mem_req   <= 1'b0;
          r_cpu_rdata <= 32'd0;
          r_bus_err   <= 1'b1;
        end
      end
    end
  end

  assign o_cpu_rdata    = r_cpu_rdata;
  assign o_cpu_misalign = r_misalign;
  assign o_cpu_bus_err  = r_bus_err;
  assign o_mem_req      = r_mem_req;
  assign o_mem_we       = r_mem_we;
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_wdata    = r_mem_wdata;
  assign o_mem_be       = r_mem_be;

endmodule
